// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory fetch sequencer.
package imem_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 8;

  localparam logic [7:0] PC_RST = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2
  } state_t;

  // PC update selector driven by the fetch FSM.
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_LOAD = 2'd1,
    PC_INC  = 2'd2,
    PC_CLR  = 2'd3
  } pc_op_t;

endpackage

// File: rtl/imem_pc_reg.sv
// Program counter: load/redirect, increment with natural wrap, clear, and end-of-program compare.
module imem_pc_reg
  import imem_pkg::*;
#(
  parameter int unsigned     AW        = AW_DEF,
  parameter logic [AW-1:0]   LAST_ADDR = {AW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  pc_op_t        op,
  input  logic [AW-1:0] load_addr,
  output logic [AW-1:0] pc,
  output logic          at_last_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= AW'(PC_RST);
    end else begin
      case (op)
        PC_LOAD: pc <= load_addr;
        PC_INC:  pc <= pc + AW'(1);
        PC_CLR:  pc <= AW'(PC_RST);
        default: pc <= pc;
      endcase
    end
  end

  assign at_last_c = (pc == LAST_ADDR);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, waits out the memory read latency, issues with valid/ready.
// Optional breakpoint support is enabled with IMEM_FETCH_BREAKPOINT_EN.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned   AW        = AW_DEF,
  parameter int unsigned   DW        = DW_DEF,
  parameter int unsigned   IMEM_LAT  = 1,
  parameter logic [AW-1:0] LAST_ADDR = {AW{1'b1}}
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          run,
  input  logic          step,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_load_addr,
  output logic [AW-1:0] Read_Address,
  input  logic [DW-1:0] instruction,
  output logic [DW-1:0] instr_out,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
`ifdef IMEM_FETCH_BREAKPOINT_EN
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  output logic          bp_hit,
`endif
  output logic          halted,
  output logic          prog_end
);

  localparam int unsigned      LAT_W    = 2;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(IMEM_LAT - 1);

  state_t          state, state_nx;
  logic [LAT_W-1:0] lat_cnt, lat_nx;
  logic            single, single_nx;
  logic            run_q;
  logic            run_rise;
  logic            capture;
  logic            valid_nx;
  logic            prog_end_nx;
  pc_op_t          pc_op;
  logic [AW-1:0]   pc_src;
  logic [AW-1:0]   pc;
  logic            at_last;
`ifdef IMEM_FETCH_BREAKPOINT_EN
  logic            bp_hit_nx;
`endif

  assign run_rise     = run & ~run_q;
  assign Read_Address = pc;

  imem_pc_reg #(
    .AW        (AW),
    .LAST_ADDR (LAST_ADDR)
  ) u_pc (
    .clk       (clk),
    .rst_n     (RST),
    .op        (pc_op),
    .load_addr (pc_src),
    .pc        (pc),
    .at_last_c (at_last)
  );

  // State, handshake and capture registers.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      single      <= 1'b0;
      run_q       <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b1;
      prog_end    <= 1'b0;
`ifdef IMEM_FETCH_BREAKPOINT_EN
      bp_hit      <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      lat_cnt     <= lat_nx;
      single      <= single_nx;
      run_q       <= run;
      instr_valid <= valid_nx;
      halted      <= (state_nx == IDLE);
      prog_end    <= prog_end_nx;
`ifdef IMEM_FETCH_BREAKPOINT_EN
      bp_hit      <= bp_hit_nx;
`endif
      if (capture) begin
        instr_out <= instruction;
        instr_pc  <= pc;
      end
    end
  end

  // Next-state, PC control and output intent.
  always_comb begin
    state_nx    = state;
    lat_nx      = lat_cnt;
    single_nx   = single;
    capture     = 1'b0;
    valid_nx    = instr_valid;
    prog_end_nx = 1'b0;
    pc_op       = PC_HOLD;
    pc_src      = pc_load_addr;
`ifdef IMEM_FETCH_BREAKPOINT_EN
    bp_hit_nx   = 1'b0;
`endif

    case (state)
      IDLE: begin
        valid_nx = 1'b0;
        lat_nx   = '0;
        if (pc_load) begin
          pc_op = PC_LOAD;
        end else if (step) begin
          single_nx = 1'b1;
          state_nx  = REQ;
        end else if (run_rise) begin
          single_nx = 1'b0;
          state_nx  = REQ;
        end
      end

      REQ: begin
        if (redirect) begin
          pc_op  = PC_LOAD;
          pc_src = redirect_addr;
          lat_nx = '0;
        end
`ifdef IMEM_FETCH_BREAKPOINT_EN
        else if (bp_en && (pc == bp_addr) && !single) begin
          bp_hit_nx = 1'b1;
          lat_nx    = '0;
          state_nx  = IDLE;
        end
`endif
        else if (lat_cnt == LAT_LAST) begin
          capture  = 1'b1;
          valid_nx = 1'b1;
          lat_nx   = '0;
          state_nx = ISSUE;
        end else begin
          lat_nx = lat_cnt + LAT_W'(1);
        end
      end

      ISSUE: begin
        if (instr_ready) begin
          valid_nx = 1'b0;
          if (redirect) begin
            pc_op  = PC_LOAD;
            pc_src = redirect_addr;
          end else if (at_last) begin
            pc_op       = PC_CLR;
            prog_end_nx = 1'b1;
          end else begin
            pc_op = PC_INC;
          end
          if ((at_last && !redirect) || single || !run) begin
            state_nx = IDLE;
          end else begin
            state_nx = REQ;
          end
        end else if (redirect) begin
          // Squash: the held instruction is dropped and never handshakes.
          valid_nx = 1'b0;
          pc_op    = PC_LOAD;
          pc_src   = redirect_addr;
          state_nx = REQ;
        end
      end

      default: begin
        valid_nx = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: issue-order scoreboard, memory-map and stability invariants.
module tb_imem_fetch_ctrl;

  logic       clk = 1'b0;
  logic       RST;
  logic       run, step, pc_load, instr_ready, redirect;
  logic [7:0] pc_load_addr, redirect_addr;
  logic [7:0] Read_Address, instruction, instr_out, instr_pc;
  logic       instr_valid, halted, prog_end;
`ifdef IMEM_FETCH_BREAKPOINT_EN
  logic       bp_en, bp_hit;
  logic [7:0] bp_addr;
`endif

  imem_fetch_ctrl dut (
    .clk           (clk),
    .RST           (RST),
    .run           (run),
    .step          (step),
    .pc_load       (pc_load),
    .pc_load_addr  (pc_load_addr),
    .Read_Address  (Read_Address),
    .instruction   (instruction),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
`ifdef IMEM_FETCH_BREAKPOINT_EN
    .bp_en         (bp_en),
    .bp_addr       (bp_addr),
    .bp_hit        (bp_hit),
`endif
    .halted        (halted),
    .prog_end      (prog_end)
  );

  always #5 clk = ~clk;

  // Memory model: content is address + 0x10, valid one clock after the address changes.
  assign instruction = Read_Address + 8'h10;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_hs = 0;
  int hs_gap = 0;
  int pe_count = 0;
  logic [7:0] exp_q[$];

  logic       prev_valid = 1'b0;
  logic       prev_hs = 1'b0;
  logic [7:0] prev_pc = 8'h00;
  logic [7:0] prev_out = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic load_pc(input logic [7:0] a);
    pc_load = 1'b1;
    pc_load_addr = a;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(halted && !instr_valid) && n < budget);
    check({name, "_idle_reached"}, 32'(halted && !instr_valid), 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin
      tick();
      n++;
    end
    check({name, "_valid_reached"}, 32'(instr_valid), 32'd1);
  endtask

  always @(posedge clk) cyc++;

  // Per-cycle checker: memory mapping, PC hold during issue, stability under backpressure, issue order.
  always @(negedge clk) begin
    if (!RST) begin
      prev_valid = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (instr_valid) begin
        check("data_map", 32'(instr_out), 32'(8'(instr_pc + 8'h10)));
        check("raddr_hold", 32'(Read_Address), 32'(instr_pc));
      end
      if (prev_valid && !prev_hs && instr_valid) begin
        check("stable_pc", 32'(instr_pc), 32'(prev_pc));
        check("stable_out", 32'(instr_out), 32'(prev_out));
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got pc %0h expected no issue (t=%0t)", instr_pc, $time);
        end else begin
          check("issue_pc", 32'(instr_pc), 32'(exp_q.pop_front()));
        end
        hs_gap = cyc - last_hs;
        last_hs = cyc;
      end
      if (prog_end) pe_count++;
      prev_valid = instr_valid;
      prev_hs = instr_valid && instr_ready;
      prev_pc = instr_pc;
      prev_out = instr_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b0; run = 1'b0; step = 1'b0; pc_load = 1'b0; pc_load_addr = 8'h00;
    instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
`ifdef IMEM_FETCH_BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = 8'h00;
`endif
    repeat (2) tick();
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_raddr", 32'(Read_Address), 32'd0);
    check("rst_prog_end", 32'(prog_end), 32'd0);
    check("rst_instr_out", 32'(instr_out), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    RST = 1'b1;
    tick();
    check("post_rst_halted", 32'(halted), 32'd1);

    // Run from reset: 0,1,2 issue every 2 cycles, run dropped before the third handshake.
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    instr_ready = 1'b1;
    run = 1'b1;
    tick();
    check("t1_req_no_valid", 32'(instr_valid), 32'd0);
    check("t1_req_busy", 32'(halted), 32'd0);
    tick();
    check("t1_first_valid", 32'(instr_valid), 32'd1);
    check("t1_first_pc", 32'(instr_pc), 32'h00);
    check("t1_first_out", 32'(instr_out), 32'h10);
    tick();
    check("t1_gap_low", 32'(instr_valid), 32'd0);
    tick();
    check("t1_second_pc", 32'(instr_pc), 32'h01);
    check("t1_second_out", 32'(instr_out), 32'h11);
    tick();
    tick();
    check("t1_third_pc", 32'(instr_pc), 32'h02);
    check("t1_third_out", 32'(instr_out), 32'h12);
    run = 1'b0;
    tick();
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_next_pc", 32'(Read_Address), 32'h03);
    check("t1_issue_gap", 32'(hs_gap), 32'd2);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure at pc 3: four stalled cycles, handshake on the fifth.
    exp_q.push_back(8'h03);
    instr_ready = 1'b0;
    pulse_step();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_valid", 32'(instr_valid), 32'd1);
      check("t2_hold_out", 32'(instr_out), 32'h13);
      check("t2_hold_raddr", 32'(Read_Address), 32'h03);
      tick();
    end
    check("t2_still_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    tick();
    check("t2_accepted", 32'(instr_valid), 32'd0);
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_next_pc", 32'(Read_Address), 32'h04);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Single step from pc 5.
    load_pc(8'h05);
    check("t3_loaded", 32'(Read_Address), 32'h05);
    check("t3_load_stays_idle", 32'(halted), 32'd1);
    exp_q.push_back(8'h05);
    pulse_step();
    wait_idle(10, "t3");
    check("t3_next_pc", 32'(Read_Address), 32'h06);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Redirect without ready squashes pc 7; run dropped mid-REQ still issues the target.
    load_pc(8'h07);
    exp_q.push_back(8'h40);
    instr_ready = 1'b0;
    run = 1'b1;
    tick();
    tick();
    check("t4_valid_pc7", 32'(instr_pc), 32'h07);
    redirect = 1'b1;
    redirect_addr = 8'h40;
    tick();
    redirect = 1'b0;
    check("t4_squashed", 32'(instr_valid), 32'd0);
    check("t4_redirect_pc", 32'(Read_Address), 32'h40);
    check("t4_not_halted", 32'(halted), 32'd0);
    instr_ready = 1'b1;
    run = 1'b0;
    wait_idle(10, "t4");
    check("t4_next_pc", 32'(Read_Address), 32'h41);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Redirect with ready: pc 7 is accepted, next issue is the target.
    load_pc(8'h07);
    exp_q.push_back(8'h07); exp_q.push_back(8'h40);
    instr_ready = 1'b0;
    pulse_step();
    wait_valid(10, "t4b");
    check("t4b_pc7", 32'(instr_pc), 32'h07);
    instr_ready = 1'b1;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    check("t4b_halted", 32'(halted), 32'd1);
    check("t4b_target_pc", 32'(Read_Address), 32'h40);
    check("t4b_one_left", 32'(exp_q.size()), 32'd1);
    pulse_step();
    wait_idle(10, "t4b");
    check("t4b_next_pc", 32'(Read_Address), 32'h41);
    check("t4b_queue_empty", 32'(exp_q.size()), 32'd0);

    // Program end and wrap.
    load_pc(8'hFE);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
    pe_count = 0;
    run = 1'b1;
    wait_idle(20, "t5");
    check("t5_prog_end_pulse", 32'(prog_end), 32'd1);
    check("t5_wrap_pc", 32'(Read_Address), 32'h00);
    tick();
    check("t5_prog_end_one_cycle", 32'(prog_end), 32'd0);
    repeat (5) tick();
    check("t5_held_run_idle", 32'(halted), 32'd1);
    check("t5_prog_end_count", 32'(pe_count), 32'd1);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    run = 1'b0;
    tick();
    exp_q.push_back(8'h00);
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_idle(10, "t5r");
    check("t5_restart_next_pc", 32'(Read_Address), 32'h01);
    check("t5_restart_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while an instruction is held.
    load_pc(8'h20);
    instr_ready = 1'b0;
    pulse_step();
    wait_valid(10, "t6");
    check("t6_pre_raddr", 32'(Read_Address), 32'h20);
    #2;
    RST = 1'b0;
    #1;
    check("t6_async_valid", 32'(instr_valid), 32'd0);
    check("t6_async_raddr", 32'(Read_Address), 32'd0);
    check("t6_async_halted", 32'(halted), 32'd1);
    check("t6_async_instr_pc", 32'(instr_pc), 32'd0);
    tick();
    RST = 1'b1;
    tick();
    tick();
    check("t6_post_idle", 32'(halted), 32'd1);
    check("t6_post_valid", 32'(instr_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
